// File: rtl/dnn_pkg.sv
// dnn_pkg
// Definitions shared by the DNN classifier and its feeders.
//   DNN_DATA_WIDTH : default bits per grid row (one bit per board column)
//   DNN_ROW_NUM    : default rows per grid
//   hold_state_t   : holding-buffer state encoding, also used by the DNN FSM file
package dnn_pkg;

  localparam int DNN_DATA_WIDTH = 8;
  localparam int DNN_ROW_NUM    = 8;

  typedef enum logic [1:0] {
    H_EMPTY  = 2'd0,
    H_FULL   = 2'd1,
    H_ISSUED = 2'd2
  } hold_state_t;

endpackage

// File: rtl/grid_frame_loader_if.sv
// grid_frame_loader_if
// Byte-stream handshake carrying board rows into the grid loader.
//   in_valid : source byte valid
//   in_sof   : current byte is row 0 of a new grid
//   in_data  : row payload, one bit per column
//   in_ready : loader can accept; a byte moves when in_valid && in_ready
// Modports: master = byte source, slave = loader.
interface grid_frame_loader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_sof,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sof,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/grid_row_assembler.sv
// grid_row_assembler
// Assembly buffer: collects ROW_NUM rows of one grid from the byte stream,
// resynchronising on in_sof and flagging framing errors.
//   clk, nrst  : clock, asynchronous active-low reset
//   bus        : byte-stream slave (drives in_ready = !asm_full)
//   clear      : holding stage has copied the rows out; frees the buffer
//   asm_full   : all ROW_NUM rows written and waiting for the copy
//   rows       : assembled row registers
//   err_resync : one-cycle pulse on an orphan byte or a restarted partial grid
module grid_row_assembler
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DNN_DATA_WIDTH,
  parameter int ROW_NUM    = DNN_ROW_NUM
) (
  input  logic                  clk,
  input  logic                  nrst,
  grid_frame_loader_if.slave    bus,
  input  logic                  clear,
  output logic                  asm_full,
  output logic [DATA_WIDTH-1:0] rows [ROW_NUM],
  output logic                  err_resync
);

  localparam int IDX_W = $clog2(ROW_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_NUM - 1);

  logic [IDX_W-1:0] idx;
  logic             accept;

  // Back-pressure only exists while a finished grid is still waiting to be
  // copied into the holding stage.
  assign bus.in_ready = !asm_full;
  assign accept       = bus.in_valid && !asm_full;

  // Row capture and framing. An SOF byte always restarts at row 0, even when
  // it arrives where the last row of a grid was expected, so a grid can only
  // complete on a non-SOF byte. A non-SOF byte with no grid in progress has
  // nowhere to go and is dropped. clear and accept never coincide because
  // clear is only raised while asm_full holds in_ready low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx        <= '0;
      asm_full   <= 1'b0;
      err_resync <= 1'b0;
      for (int i = 0; i < ROW_NUM; i++) rows[i] <= '0;
    end else begin
      err_resync <= 1'b0;
      if (clear) asm_full <= 1'b0;
      if (accept) begin
        if (bus.in_sof) begin
          rows[0] <= bus.in_data;
          idx     <= IDX_W'(1);
          if (idx != '0) err_resync <= 1'b1;
        end else if (idx == '0) begin
          err_resync <= 1'b1;
        end else begin
          rows[idx] <= bus.in_data;
          if (idx == LAST_IDX) begin
            asm_full <= 1'b1;
            idx      <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/grid_frame_loader.sv
// grid_frame_loader
// Upstream feeder for the DNN block: assembles ROW_NUM-row grids from a byte
// stream and presents each as a single-cycle pulse once the DNN is free.
//   clk, nrst     : clock, asynchronous active-low reset
//   bus           : byte-stream slave (in_valid/in_sof/in_data/in_ready)
//   nn_occupied   : DNN busy (level-sensitive)
//   grid_ov       : one-cycle grid-valid pulse to the DNN
//   grid_od       : holding-buffer rows, stable around each pulse
//   err_resync    : one-cycle framing-error pulse
//   frames_issued : wrapping count of grid_ov pulses
module grid_frame_loader
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DNN_DATA_WIDTH,
  parameter int ROW_NUM    = DNN_ROW_NUM,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  grid_frame_loader_if.slave    bus,
  input  logic                  nn_occupied,
  output logic                  grid_ov,
  output logic [DATA_WIDTH-1:0] grid_od [ROW_NUM],
  output logic                  err_resync,
  output logic [CNT_WIDTH-1:0]  frames_issued
);

  hold_state_t           state;
  logic                  asm_full;
  logic                  hold_load;
  logic [DATA_WIDTH-1:0] asm_rows [ROW_NUM];

  // The copy into holding and the release of the assembly buffer share one
  // edge, so the assembler is cleared straight from the current state.
  assign hold_load = (state == H_EMPTY) && asm_full;

  grid_row_assembler #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROW_NUM    (ROW_NUM)
  ) u_asm (
    .clk        (clk),
    .nrst       (nrst),
    .bus        (bus),
    .clear      (hold_load),
    .asm_full   (asm_full),
    .rows       (asm_rows),
    .err_resync (err_resync)
  );

  // Holding FSM. grid_od is loaded only on the EMPTY->FULL copy, so it stays
  // put through the pulse and the ISSUED guard cycle that follows, which is
  // when the DNN raises its occupied flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= H_EMPTY;
      grid_ov       <= 1'b0;
      frames_issued <= '0;
      for (int i = 0; i < ROW_NUM; i++) grid_od[i] <= '0;
    end else begin
      grid_ov <= 1'b0;
      case (state)
        H_EMPTY: begin
          if (asm_full) begin
            grid_od <= asm_rows;
            state   <= H_FULL;
          end
        end
        H_FULL: begin
          if (!nn_occupied) begin
            grid_ov       <= 1'b1;
            frames_issued <= frames_issued + CNT_WIDTH'(1);
            state         <= H_ISSUED;
          end
        end
        H_ISSUED: state <= H_EMPTY;
        default:  state <= H_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_frame_loader.sv
// tb_grid_frame_loader
// Directed bench for grid_frame_loader. A second instance with a 2-bit
// counter sees identical stimulus and is used for the wrap check.
module tb_grid_frame_loader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nn_occupied = 1'b0;

  logic        grid_ov, err_resync;
  logic [7:0]  grid_od [8];
  logic [15:0] frames_issued;

  logic        grid_ov_w, err_resync_w;
  logic [7:0]  grid_od_w [8];
  logic [1:0]  frames_issued_w;

  grid_frame_loader_if #(.DATA_WIDTH(8)) bus ();
  grid_frame_loader_if #(.DATA_WIDTH(8)) bus_w ();

  assign bus_w.in_valid = bus.in_valid;
  assign bus_w.in_sof   = bus.in_sof;
  assign bus_w.in_data  = bus.in_data;

  grid_frame_loader #(.DATA_WIDTH(8), .ROW_NUM(8), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .bus           (bus),
    .nn_occupied   (nn_occupied),
    .grid_ov       (grid_ov),
    .grid_od       (grid_od),
    .err_resync    (err_resync),
    .frames_issued (frames_issued)
  );

  grid_frame_loader #(.DATA_WIDTH(8), .ROW_NUM(8), .CNT_WIDTH(2)) dut_w (
    .clk           (clk),
    .nrst          (nrst),
    .bus           (bus_w),
    .nn_occupied   (nn_occupied),
    .grid_ov       (grid_ov_w),
    .grid_od       (grid_od_w),
    .err_resync    (err_resync_w),
    .frames_issued (frames_issued_w)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] F1  = 64'h8040201008040201;
  localparam logic [63:0] F2  = 64'h1716151413121110;
  localparam logic [63:0] F3  = 64'hA7A6A5A4A3A2A1A0;
  localparam logic [63:0] FRS = 64'h6766656463626155;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int pulse_w_cnt = 0;
  logic [63:0] pulse_q [$];
  int          pulse_cyc_q [$];

  // Cycle counter used to time the spacing between grid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Away from the active edge, record every grid pulse with the rows it
  // carries, and count framing-error pulses.
  always @(negedge clk) begin
    if (nrst && grid_ov) begin
      pulse_q.push_back(packGrid(grid_od));
      pulse_cyc_q.push_back(cyc);
    end
    if (nrst && err_resync) err_cnt <= err_cnt + 1;
    if (nrst && grid_ov_w) pulse_w_cnt <= pulse_w_cnt + 1;
  end

  function automatic logic [63:0] packGrid(input logic [7:0] g [8]);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = g[i];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and hold it until it transfers; returns #1 after the
  // accepting edge.
  task automatic applyStimulus(input logic sof, input logic [7:0] data);
    logic ready_now;
    bit   done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = data;
    for (int k = 0; k < 200 && !done; k++) begin
      ready_now = bus.in_ready;
      @(posedge clk);
      #1;
      if (ready_now) done = 1;
    end
    if (!done) checkOutput("xfer_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic sendFrame(input logic [63:0] g);
    for (int i = 0; i < 8; i++) applyStimulus(i == 0, g[i*8 +: 8]);
  endtask

  task automatic applyReset();
    nrst = 1'b0;
    waitCycles(2);
    nrst = 1'b1;
    waitCycles(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base_err;
    int base_pulse;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    waitCycles(2);
    nrst = 1'b1;
    #1;

    // Reset state
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_grid_ov", 64'(grid_ov), 64'd0);
    checkOutput("rst_err", 64'(err_resync), 64'd0);
    checkOutput("rst_frames", 64'(frames_issued), 64'd0);
    checkOutput("rst_grid_od", packGrid(grid_od), 64'd0);

    // Nominal frame with exact latency
    sendFrame(F1);
    checkOutput("nom_ready_low", 64'(bus.in_ready), 64'd0);
    waitCycles(1);
    checkOutput("nom_ready_back", 64'(bus.in_ready), 64'd1);
    checkOutput("nom_ov_early", 64'(grid_ov), 64'd0);
    checkOutput("nom_copy", packGrid(grid_od), F1);
    waitCycles(1);
    checkOutput("nom_ov", 64'(grid_ov), 64'd1);
    checkOutput("nom_grid", packGrid(grid_od), F1);
    checkOutput("nom_frames", 64'(frames_issued), 64'd1);
    waitCycles(1);
    checkOutput("nom_ov_end", 64'(grid_ov), 64'd0);
    checkOutput("nom_grid_hold", packGrid(grid_od), F1);
    checkOutput("nom_pulses", 64'(pulse_q.size()), 64'd1);

    // Back-pressure with the DNN held busy
    nn_occupied = 1'b1;
    sendFrame(F1);
    sendFrame(F2);
    checkOutput("bp_ready_low", 64'(bus.in_ready), 64'd0);
    waitCycles(5);
    checkOutput("bp_ready_stays", 64'(bus.in_ready), 64'd0);
    checkOutput("bp_no_pulse", 64'(pulse_q.size()), 64'd1);
    checkOutput("bp_frames", 64'(frames_issued), 64'd1);
    nn_occupied = 1'b0;
    waitCycles(8);
    checkOutput("bp_pulses", 64'(pulse_q.size()), 64'd3);
    if (pulse_q.size() >= 3) begin
      checkOutput("bp_first", pulse_q[1], F1);
      checkOutput("bp_second", pulse_q[2], F2);
      checkOutput("bp_spacing", 64'(pulse_cyc_q[2] - pulse_cyc_q[1]), 64'd3);
    end
    checkOutput("bp_ready_back", 64'(bus.in_ready), 64'd1);
    sendFrame(F3);
    waitCycles(6);
    checkOutput("bp_third_cnt", 64'(pulse_q.size()), 64'd4);
    if (pulse_q.size() >= 4) checkOutput("bp_third", pulse_q[3], F3);
    checkOutput("bp_frames_end", 64'(frames_issued), 64'd4);

    // Resync: SOF on the 4th byte
    base_err = err_cnt;
    applyStimulus(1'b1, 8'h31);
    applyStimulus(1'b0, 8'h32);
    applyStimulus(1'b0, 8'h33);
    applyStimulus(1'b1, 8'h55);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 8'h60 + 8'(i));
    waitCycles(6);
    checkOutput("rs_err_once", 64'(err_cnt - base_err), 64'd1);
    checkOutput("rs_no_early", 64'(pulse_q.size()), 64'd4);
    applyStimulus(1'b0, 8'h67);
    waitCycles(6);
    checkOutput("rs_pulse", 64'(pulse_q.size()), 64'd5);
    if (pulse_q.size() >= 5) checkOutput("rs_grid", pulse_q[4], FRS);
    checkOutput("rs_frames", 64'(frames_issued), 64'd5);
    checkOutput("rs_err_total", 64'(err_cnt - base_err), 64'd1);

    // Reset mid-frame
    applyStimulus(1'b1, 8'hC0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 8'hC0 + 8'(i));
    nrst = 1'b0;
    #1;
    checkOutput("mr_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mr_ov", 64'(grid_ov), 64'd0);
    checkOutput("mr_err", 64'(err_resync), 64'd0);
    checkOutput("mr_frames", 64'(frames_issued), 64'd0);
    checkOutput("mr_grid", packGrid(grid_od), 64'd0);
    waitCycles(2);
    nrst = 1'b1;
    waitCycles(5);
    checkOutput("mr_no_pulse", 64'(pulse_q.size()), 64'd5);
    sendFrame(F3);
    waitCycles(6);
    checkOutput("mr_after_cnt", 64'(pulse_q.size()), 64'd6);
    if (pulse_q.size() >= 6) checkOutput("mr_after_grid", pulse_q[5], F3);
    checkOutput("mr_after_frames", 64'(frames_issued), 64'd1);

    // Orphan bytes after reset
    applyReset();
    base_err   = err_cnt;
    base_pulse = pulse_q.size();
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22);
    waitCycles(3);
    checkOutput("or_err", 64'(err_cnt - base_err), 64'd2);
    checkOutput("or_frames", 64'(frames_issued), 64'd0);
    checkOutput("or_grid", packGrid(grid_od), 64'd0);
    checkOutput("or_no_pulse", 64'(pulse_q.size() - base_pulse), 64'd0);
    checkOutput("or_ready", 64'(bus.in_ready), 64'd1);

    // Counter wrap on the 2-bit instance
    applyReset();
    base_pulse = pulse_w_cnt;
    for (int f = 0; f < 5; f++) sendFrame(F2);
    waitCycles(10);
    checkOutput("wr_frames16", 64'(frames_issued), 64'd5);
    checkOutput("wr_frames2", 64'(frames_issued_w), 64'd1);
    checkOutput("wr_pulses2", 64'(pulse_w_cnt - base_pulse), 64'd5);
    checkOutput("wr_grid2", packGrid(grid_od_w), F2);
    checkOutput("wr_err2", 64'(err_resync_w), 64'd0);
    checkOutput("wr_ready2", 64'(bus_w.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_frame_loader.md
# grid_frame_loader

Upstream feeder for the `DNN` block. It accepts a byte stream of board rows with a start-of-frame marker and assembles complete `ROW_NUM`-row grids. A two-stage assembly/holding buffer presents each grid to `DNN` as a single-cycle `input_grid_iv`-compatible pulse, and only when `DNN` reports it is not occupied. This lets the byte source keep streaming while a previous grid waits or is being classified.

## Interface
- `DATA_WIDTH`, default 8: bits per row (one bit per column); must equal the `DNN` `DATA_WIDTH`.
- `ROW_NUM`, default 8: rows per grid; must equal the `DNN` `ROW_NUM`; ≥2.
- `CNT_WIDTH`, default 16: width of the issued-frame counter.
- Clocking and reset (already decided): reset `nrst`, asynchronous, active-low; clock `clk`.
- `in_valid`, input, 1: source byte valid.
- `in_sof`, input, 1: marks the current byte as row 0 of a new grid.
- `in_data`, input, `DATA_WIDTH`: row payload.
- `in_ready`, output, 1: loader can accept; a byte transfers when `in_valid && in_ready`.
- `nn_occupied`, input, 1: `DNN` busy; connects to `NN_occupied`.
- `grid_ov`, output, 1: one-cycle grid-valid pulse; connects to `input_grid_iv`.
- `grid_od[ROW_NUM]`, output, `DATA_WIDTH` each: holding-buffer rows; connects to `row_input_id`.
- `err_resync`, output, 1: one-cycle pulse on a framing error.
- `frames_issued`, output, `CNT_WIDTH`: count of `grid_ov` pulses; wraps.

## Operation
- **Assembly buffer**
  - Holds `ROW_NUM` row registers, a row index `idx` (0..`ROW_NUM`-1) and an `asm_full` flag.
  - `in_ready = !asm_full`.
  - Accepted byte with `in_sof`: written to row 0 and `idx` becomes 1. If `idx` was not 0, the partial grid is discarded and `err_resync` pulses.
  - Accepted byte without `in_sof`:
    - If `idx == 0`, the byte is consumed and dropped, and `err_resync` pulses.
    - Otherwise the byte is written to row `idx` and `idx` increments.
  - Writing row `ROW_NUM`-1 sets `asm_full` and returns `idx` to 0.
- **Holding FSM**, with states `H_EMPTY`, `H_FULL`, `H_ISSUED`:
  - `H_EMPTY` with `asm_full`: copy the assembly rows into the `grid_od` registers, clear `asm_full`, go to `H_FULL`.
  - `H_FULL` with `!nn_occupied`: register `grid_ov` high for the next cycle, increment `frames_issued`, go to `H_ISSUED`.
  - `H_FULL` with `nn_occupied`: stay.
  - `H_ISSUED`: unconditionally go to `H_EMPTY` after one cycle. This is the guard cycle during which `DNN` raises `NN_occupied`.
- `grid_od` changes only on the assembly-to-holding copy. It is stable during the `grid_ov` cycle and the cycle after it.
- The assembly buffer keeps accepting while the holding buffer is `H_FULL` or `H_ISSUED`. Back-pressure starts only when both buffers are full.

## Timing
- **Reset values**:
  - `in_ready`=1, `grid_ov`=0, `err_resync`=0, `frames_issued`=0.
  - `grid_od` all zero, `idx`=0, `asm_full`=0, state `H_EMPTY`.
- **Mid-operation reset**: any partial or held grid is lost and no `grid_ov` is emitted.
- **Minimum latency**, last row accepted at edge N with the holding buffer empty and `DNN` idle:
  - Copy into holding at edge N+1.
  - `grid_ov` high during cycle N+2 to N+3.
  - `in_ready` high again from edge N+1.
- **Minimum spacing**: consecutive `grid_ov` pulses are at least 3 cycles apart (FULL → ISSUED → EMPTY → copy → FULL).
- **Simultaneous events**:
  - The copy and the clearing of `asm_full` happen on the same edge. No byte can be accepted that cycle, because `in_ready` was low.
  - `in_sof` on the byte that would complete a grid is treated as a restart, not a completion.
- **`nn_occupied` semantics**: level-sensitive. Held high indefinitely, it keeps the holding buffer in `H_FULL` and, once the assembly buffer fills, `in_ready` low.
- **`frames_issued`**: wraps from 2^`CNT_WIDTH`-1 to 0.

## Structure
- Shared package `dnn_pkg`:
  - `DATA_WIDTH` and `ROW_NUM` defaults.
  - Holding-state enum `hold_state_t`, shared with the `DNN` FSM encoding file.
- One natural sub-module, `grid_row_assembler`: the assembly buffer, `idx` and the `err_resync` logic, exposing `asm_full`, the rows and a `clear` input.
- The holding FSM, the counter and the output registers stay in `grid_frame_loader`.

## Test plan
- **Nominal frame**: 8 bytes 0x01..0x80 with `in_sof` on the first byte, `nn_occupied`=0 → one `grid_ov` pulse 2 cycles after the last byte; `grid_od[0..7]`=0x01..0x80; `frames_issued`=1.
- **Back-pressure**: `nn_occupied` held 1 while 3 frames are streamed →
  - the first grid is held in holding and the second fills the assembly buffer;
  - `in_ready` goes low on the 16th byte;
  - releasing `nn_occupied` yields pulses carrying frame 1 and frame 2, in order, ≥3 cycles apart;
  - the third frame is then accepted.
- **Resync**: `in_sof` on the 4th byte of a frame → `err_resync` pulses once; the 4th byte becomes row 0; a grid issues only after 7 more bytes.
- **Orphan bytes**: 2 bytes without `in_sof` after reset → 2 `err_resync` pulses, no writes, `frames_issued` stays 0.
- **Reset mid-frame**: `nrst` asserted after 5 bytes → all outputs return to reset values; a following full frame issues normally.
- **Counter wrap**: with `CNT_WIDTH`=2, issue 5 frames → `frames_issued` reads 1.
